// File: rtl/if_fetch_unit_if.sv
// Instruction-memory port of the fetch unit.
// Request channel: valid/ready. Response channel: valid only, with no backpressure.
// master = fetch unit side, slave = instruction memory side.
interface if_fetch_unit_if;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface : if_fetch_unit_if

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the RV32 pipeline and producer side
// of the IF/ID register. It keeps one fetch outstanding, holds the IF/ID bundle
// under stall using a one-entry skid, and squashes wrong-path fetches on redirect.
//
// Optional feature macro: IFETCH_MISALIGN_CHK_EN
//   defined   : a misaligned redirect target raises fetch_misalign. Fetching
//               then stays parked until an aligned redirect or reset.
//   undefined : fetch_misalign is tied low. Redirect targets are word-aligned
//               by clearing the two low bits.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    if_fetch_unit_if.master       imem,
    input  logic                  stall_i,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  if_valid,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_instr,
    output logic                  fetch_misalign
);

    // Fetch FSM encoding.
    localparam logic [1:0] ST_REQ  = 2'd0;  // presenting a request
    localparam logic [1:0] ST_WAIT = 2'd1;  // one request outstanding
    localparam logic [1:0] ST_FULL = 2'd2;  // output slot busy, skid holds next bundle

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    // Sequential PC increment. Wraps modulo 2^32.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    // State registers and their next-state values.
    logic [1:0]  state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] req_pc_q,     req_pc_d;
    logic        drop_q,       drop_d;
    logic [31:0] skid_pc_q,    skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        valid_q,      valid_d;
    logic [31:0] out_pc_q,     out_pc_d;
    logic [31:0] out_instr_q,  out_instr_d;

    // Decoded controls.
    logic        req_valid_s;
    logic        fire_s;
    logic        consume_s;
    logic        slot_free_s;
    logic        park_s;
    logic [31:0] redirect_tgt_s;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic        misalign_q, misalign_d;
    logic        misalign_tgt_s;

    assign misalign_tgt_s = (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt_s = redirect_pc;
    assign park_s         = misalign_q;

    // Misalign flag follows the alignment of the most recent redirect target.
    always_comb begin
        misalign_d = misalign_q;
        if (redirect_valid) begin
            misalign_d = misalign_tgt_s;
        end else begin
            misalign_d = misalign_q;
        end
    end

    // Misalign flag register.
    always_ff @(posedge clock) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_misalign = misalign_q;
`else
    assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;
    assign park_s         = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    // The request decodes directly from state and pc. It is held low during
    // reset and while parked on a misaligned target.
    assign req_valid_s         = (state_q == ST_REQ) && !reset && !park_s;
    assign imem.imem_req_valid = req_valid_s;
    assign imem.imem_req_addr  = pc_q;

    assign fire_s      = req_valid_s && imem.imem_req_ready;
    assign consume_s   = valid_q && !stall_i;
    assign slot_free_s = !valid_q || consume_s;

    // Next-state logic. A redirect overrides stall, consume and responses.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        drop_d       = drop_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        valid_d      = valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;

        if (redirect_valid) begin
            pc_d    = redirect_tgt_s;
            valid_d = 1'b0;
            case (state_q)
                ST_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        // The in-flight response lands now and is thrown away.
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        // The response is still coming and must be swallowed.
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_REQ: begin
                    if (fire_s) begin
                        // The old-pc request leaves this cycle, so squash its response.
                        req_pc_d = pc_q;
                        drop_d   = 1'b1;
                        state_d  = ST_WAIT;
                    end else begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end
                end
                ST_FULL: begin
                    // The skid content is wrong-path. Leaving FULL discards it.
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                end
                default: begin
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                end
            endcase
        end else begin
            if (consume_s) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end

            case (state_q)
                ST_REQ: begin
                    if (fire_s) begin
                        req_pc_d = pc_q;
                        pc_d     = next_word_addr(pc_q);
                        state_d  = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (!imem.imem_rsp_valid) begin
                        state_d = ST_WAIT;
                    end else if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else if (slot_free_s) begin
                        out_pc_d    = req_pc_q;
                        out_instr_d = imem.imem_rsp_data;
                        valid_d     = 1'b1;
                        state_d     = ST_REQ;
                    end else begin
                        skid_pc_d    = req_pc_q;
                        skid_instr_d = imem.imem_rsp_data;
                        state_d      = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (consume_s) begin
                        out_pc_d    = skid_pc_q;
                        out_instr_d = skid_instr_q;
                        valid_d     = 1'b1;
                        state_d     = ST_REQ;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    // State and IF/ID output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= 32'h0000_0000;
            drop_q       <= 1'b0;
            skid_pc_q    <= 32'h0000_0000;
            skid_instr_q <= NOP_INSTR;
            valid_q      <= 1'b0;
            out_pc_q     <= 32'h0000_0000;
            out_instr_q  <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            drop_q       <= drop_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            valid_q      <= valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
        end
    end

    assign if_valid = valid_q;
    assign if_pc    = out_pc_q;
    assign if_instr = out_instr_q;

endmodule : if_fetch_unit

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit. A driver produces random stall, redirect, ready and
// response-latency stimulus. A behavioural memory returns a fixed word for each
// address. The reference model is the program-order stream that IF/ID should
// receive: from reset or from a redirect target, consecutive words in order.
// The driver fills the expected queue with that stream. A separate monitor
// pops and compares each bundle that IF/ID consumes.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } bundle_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_misalign;

    if_fetch_unit_if imem_bus ();

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem           (imem_bus),
        .stall_i        (stall_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clock = ~clock;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          n_consumed = 0;
    bundle_t     exp_q[$];
    logic [31:0] base_pc;
    bit          exp_parked;
    bit          pending;
    bit          late;
    int          rsp_cnt;
    logic [31:0] fire_addr;

    // Monitor state.
    bit          prev_hold = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_00A0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_redirect(input logic [31:0] t);
        exp_q.delete();
`ifdef IFETCH_MISALIGN_CHK_EN
        if (t[1:0] != 2'b00) begin
            exp_parked = 1'b1;
        end else begin
            exp_parked = 1'b0;
            base_pc    = t;
        end
`else
        exp_parked = 1'b0;
        base_pc    = {t[31:2], 2'b00};
`endif
    endtask

    task automatic topup();
        bundle_t b;
        if (!exp_parked) begin
            while (exp_q.size() < 16) begin
                b.pc    = base_pc;
                b.instr = mem_word(base_pc);
                exp_q.push_back(b);
                base_pc = base_pc + 32'd4;
            end
        end
    endtask

    // One clock cycle of stimulus. Inputs are driven just after the rising edge.
    // Fires are sampled at the falling edge.
    task automatic step(input bit st, input bit rd, input logic [31:0] tgt,
                        input bit rdy, input int kmax, input bit rst);
        @(posedge clock);
        #1;
        reset                   = rst;
        stall_i                 = st;
        redirect_valid          = rd;
        redirect_pc             = tgt;
        imem_bus.imem_req_ready = rdy;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = $urandom;
        if (rst) begin
            if (pending) begin
                late    = 1'b1;
                pending = 1'b0;
            end
        end else if (late) begin
            // Stale response reaching the DUT right after reset.
            imem_bus.imem_rsp_valid = 1'b1;
            imem_bus.imem_rsp_data  = 32'hDEAD_BEEF;
            late = 1'b0;
        end else if (pending) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                imem_bus.imem_rsp_valid = 1'b1;
                imem_bus.imem_rsp_data  = mem_word(fire_addr);
                pending = 1'b0;
            end
        end
        if (rst) begin
            exp_q.delete();
            base_pc    = RST_PC;
            exp_parked = 1'b0;
        end else if (rd) begin
            model_redirect(tgt);
        end
        topup();
        @(negedge clock);
        if (!rst && imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
            check("one_outstanding", 32'(pending), 32'd0);
            pending   = 1'b1;
            rsp_cnt   = int'($urandom_range(kmax, 1));
            fire_addr = imem_bus.imem_req_addr;
        end
    endtask

    task automatic check_reset_state();
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'h0000_0000);
        check("rst_if_instr", if_instr, 32'h0000_0013);
        check("rst_misalign", 32'(fetch_misalign), 32'd0);
        check("rst_req_valid_after", 32'(imem_bus.imem_req_valid), 32'd1);
    endtask

    // Monitor: compares consumed bundles, stall hold and misalign status.
    initial begin
        bundle_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                check("req_valid_in_reset", 32'(imem_bus.imem_req_valid), 32'd0);
                prev_hold = 1'b0;
            end else if (redirect_valid) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", 32'(if_valid), 32'd1);
                    check("hold_pc", if_pc, prev_pc);
                    check("hold_instr", if_instr, prev_instr);
                end
                if (exp_parked) begin
                    check("parked_misalign", 32'(fetch_misalign), 32'd1);
                    check("parked_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
                    check("parked_if_valid", 32'(if_valid), 32'd0);
                end else begin
                    check("misalign_low", 32'(fetch_misalign), 32'd0);
                end
                if (if_valid && !stall_i) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_bundle: got pc %h, none expected", if_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_pc", if_pc, e.pc);
                        check("stream_instr", if_instr, e.instr);
                        n_consumed++;
                    end
                end
                prev_hold  = if_valid && stall_i;
                prev_pc    = if_pc;
                prev_instr = if_instr;
            end
        end
    end

    // Driver.
    initial begin
        logic [31:0] tgt;
        bit          st;
        bit          rd;
        bit          rdy;
        int          snap;
        reset                   = 1'b1;
        stall_i                 = 1'b0;
        redirect_valid          = 1'b0;
        redirect_pc             = 32'h0000_0000;
        imem_bus.imem_req_ready = 1'b0;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = 32'h0000_0000;
        pending                 = 1'b0;
        late                    = 1'b0;
        rsp_cnt                 = 0;
        fire_addr               = 32'h0000_0000;
        base_pc                 = RST_PC;
        exp_parked              = 1'b0;

        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1);

        // With ready=1 and k=1 the bench expects a request every 2nd cycle and a bundle every 2nd cycle.
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
            if (c == 0) check_reset_state();
            check("req_valid_pattern", 32'(imem_bus.imem_req_valid), 32'((c % 2) == 0));
            check("if_valid_pattern", 32'(if_valid), 32'((c >= 2) && ((c % 2) == 0)));
        end

        // Stall for 5 cycles while the next response arrives.
        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3500; i++) begin
            if (i == 3000) begin
                repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 3, 1'b1);
                step(1'b0, 1'b0, 32'h0, 1'b1, 3, 1'b0);
                check_reset_state();
            end
            st  = ($urandom_range(2, 0) == 0);
            rd  = ($urandom_range(24, 0) == 0);
            rdy = ($urandom_range(2, 0) != 0);
            if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
            else                           tgt = $urandom;
`ifdef IFETCH_MISALIGN_CHK_EN
            tgt = tgt & 32'hFFFF_FFFC;
`endif
            step(st, rd, tgt, rdy, 3, 1'b0);
        end

        // Fetch across the top of the address space.
        snap = n_consumed;
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        check("wrap_progress", 32'(n_consumed >= snap + 3), 32'd1);

        // Redirect to a misaligned target, then to an aligned target.
        step(1'b0, 1'b1, 32'h0000_0202, 1'b1, 2, 1'b0);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 2, 1'b0);
        snap = n_consumed;
        step(1'b0, 1'b1, 32'h0000_0300, 1'b1, 2, 1'b0);
        repeat (20) step(1'b0, 1'b0, 32'h0, 1'b1, 2, 1'b0);
        check("resume_after_aligned", 32'(n_consumed > snap), 32'd1);

        check("overall_progress", 32'(n_consumed >= 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_fetch_unit
